// File: rtl/execute_super_pkg.sv
// Shared Y86-64 definitions for the execute stage.
// Contents:
//   icode_t  - instruction codes IHALT..IPOPQ
//   alu_op_t - ALU operation codes used for OPq (ifun)
//   cond_t   - condition codes for cmovXX / jXX (ifun)
//   cc_t     - condition-code register layout {ZF, SF, OF}
//   CC_*     - bit indices and reset value of the CC register
package y86_pkg;

    typedef enum logic [3:0] {
        IHALT   = 4'h0,
        INOP    = 4'h1,
        IRRMOVQ = 4'h2,
        IIRMOVQ = 4'h3,
        IRMMOVQ = 4'h4,
        IMRMOVQ = 4'h5,
        IOPQ    = 4'h6,
        IJXX    = 4'h7,
        ICALL   = 4'h8,
        IRET    = 4'h9,
        IPUSHQ  = 4'hA,
        IPOPQ   = 4'hB
    } icode_t;

    typedef enum logic [3:0] {
        ALUADD = 4'h0,
        ALUSUB = 4'h1,
        ALUAND = 4'h2,
        ALUXOR = 4'h3
    } alu_op_t;

    typedef enum logic [3:0] {
        C_YES = 4'h0,
        C_LE  = 4'h1,
        C_L   = 4'h2,
        C_E   = 4'h3,
        C_NE  = 4'h4,
        C_GE  = 4'h5,
        C_G   = 4'h6
    } cond_t;

    // Field order makes the packed vector cc[2]=ZF, cc[1]=SF, cc[0]=OF.
    typedef struct packed {
        logic zf;
        logic sf;
        logic of;
    } cc_t;

    localparam int unsigned CC_ZF = 2;
    localparam int unsigned CC_SF = 1;
    localparam int unsigned CC_OF = 0;

    localparam cc_t CC_RESET = '{zf: 1'b1, sf: 1'b0, of: 1'b0};

endpackage

// File: rtl/execute_super_if.sv
// Decode -> execute -> memory/writeback bundle for the execute stage.
// Signals:
//   icode, ifun        - instruction and function code from decode
//   valA, valB, valC   - operands / constant from decode
//   valE               - ALU result towards memory/writeback
//   cnd                - branch / conditional-move condition
// Modports:
//   master - pipeline side: drives decode fields, consumes valE/cnd
//   slave  - execute stage: consumes decode fields, drives valE/cnd
interface execute_super_if #(
    parameter int WIDTH = 64
);
    logic [3:0]       icode;
    logic [3:0]       ifun;
    logic [WIDTH-1:0] valA;
    logic [WIDTH-1:0] valB;
    logic [WIDTH-1:0] valC;
    logic [WIDTH-1:0] valE;
    logic             cnd;

    modport master (
        output icode, ifun, valA, valB, valC,
        input  valE, cnd
    );

    modport slave (
        input  icode, ifun, valA, valB, valC,
        output valE, cnd
    );
endinterface

// File: rtl/execute_super_alu64.sv
// Two's-complement ALU for the execute stage: result = b op a.
// Ports:
//   a, b   - operands (b is the left-hand side for subtraction)
//   op     - ALU op code (ALUADD/ALUSUB/ALUAND/ALUXOR); others give 0
//   result - wrapped result
//   zf, sf - zero / sign of result
//   of     - signed overflow (add/sub only)
module alu64
    import y86_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic [WIDTH-1:0] result,
    output logic             zf,
    output logic             sf,
    output logic             of
);
    localparam int unsigned MSB = WIDTH - 1;

    always_comb begin
        result = '0;
        of     = 1'b0;
        case (op)
            ALUADD: begin
                result = b + a;
                of     = (a[MSB] == b[MSB]) && (result[MSB] != b[MSB]);
            end
            ALUSUB: begin
                result = b - a;
                of     = (a[MSB] != b[MSB]) && (result[MSB] != b[MSB]);
            end
            ALUAND: result = b & a;
            ALUXOR: result = b ^ a;
            default: begin
                result = '0;
                of     = 1'b0;
            end
        endcase
    end

    assign zf = (result == '0);
    assign sf = result[MSB];
endmodule

// File: rtl/execute_super.sv
// Y86-64 execute stage: computes valE via alu64, holds the CC register
// (ZF, SF, OF) and evaluates cnd for cmovXX / jXX.
// Ports:
//   clk   - CC register updates on rising edge
//   rst_n - asynchronous active-low reset, CC <= {ZF=1,SF=0,OF=0}
//   bus   - execute_super_if.slave: icode/ifun/valA/valB/valC in,
//           valE/cnd out (both combinational)
module execute_super
    import y86_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    execute_super_if.slave        bus
);
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [3:0]       alu_op;
    logic [WIDTH-1:0] alu_result;
    logic             alu_zf;
    logic             alu_sf;
    logic             alu_of;
    cc_t              cc;

    // Operand/op selection: every icode is mapped onto b op a so that a
    // single ALU serves all instructions; zero-result icodes use 0 + 0.
    always_comb begin
        alu_a  = '0;
        alu_b  = '0;
        alu_op = ALUADD;
        case (bus.icode)
            IRRMOVQ: alu_a = bus.valA;
            IIRMOVQ: alu_a = bus.valC;
            IRMMOVQ, IMRMOVQ: begin
                alu_a = bus.valC;
                alu_b = bus.valB;
            end
            IOPQ: begin
                alu_a  = bus.valA;
                alu_b  = bus.valB;
                alu_op = bus.ifun;
            end
            ICALL, IPUSHQ: begin
                alu_a  = WIDTH'(8);
                alu_b  = bus.valB;
                alu_op = ALUSUB;
            end
            IRET, IPOPQ: begin
                alu_a = WIDTH'(8);
                alu_b = bus.valB;
            end
            default: begin
                alu_a  = '0;
                alu_b  = '0;
                alu_op = ALUADD;
            end
        endcase
    end

    alu64 #(
        .WIDTH (WIDTH)
    ) u_alu (
        .a      (alu_a),
        .b      (alu_b),
        .op     (alu_op),
        .result (alu_result),
        .zf     (alu_zf),
        .sf     (alu_sf),
        .of     (alu_of)
    );

    assign bus.valE = alu_result;

    // CC is written only by OPq, including unsupported ifun (result 0).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cc <= CC_RESET;
        end else if (bus.icode == IOPQ) begin
            cc <= '{zf: alu_zf, sf: alu_sf, of: alu_of};
        end
    end

    // Conditions use the registered CC, so an OPq affects the next
    // instruction rather than itself.
    always_comb begin
        bus.cnd = 1'b0;
        if (bus.icode == IRRMOVQ || bus.icode == IJXX) begin
            case (bus.ifun)
                C_YES:   bus.cnd = 1'b1;
                C_LE:    bus.cnd = (cc.sf ^ cc.of) | cc.zf;
                C_L:     bus.cnd = cc.sf ^ cc.of;
                C_E:     bus.cnd = cc.zf;
                C_NE:    bus.cnd = ~cc.zf;
                C_GE:    bus.cnd = ~(cc.sf ^ cc.of);
                C_G:     bus.cnd = ~(cc.sf ^ cc.of) & ~cc.zf;
                default: bus.cnd = 1'b0;
            endcase
        end
    end
endmodule

// File: tb/tb_execute_super.sv
// Self-checking bench for execute_super: directed plan followed by
// randomized instructions checked against a behavioural model.
module tb_execute_super;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    execute_super_if #(.WIDTH(64)) bus ();

    execute_super #(.WIDTH(64)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int unsigned passed = 0;
    int unsigned total  = 0;

    // Reference condition flags
    logic m_zf = 1'b1;
    logic m_sf = 1'b0;
    logic m_of = 1'b0;

    function automatic logic [63:0] ref_vale(input logic [3:0] ic, input logic [3:0] fn,
                                             input logic [63:0] a, input logic [63:0] b,
                                             input logic [63:0] c);
        case (ic)
            4'd2: return a;
            4'd3: return c;
            4'd4, 4'd5: return b + c;
            4'd6: begin
                case (fn)
                    4'd0: return b + a;
                    4'd1: return b - a;
                    4'd2: return b & a;
                    4'd3: return b ^ a;
                    default: return 64'd0;
                endcase
            end
            4'd8, 4'd10: return b - 64'd8;
            4'd9, 4'd11: return b + 64'd8;
            default: return 64'd0;
        endcase
    endfunction

    // Overflow judged by exact 65-bit signed arithmetic.
    function automatic logic ref_of(input logic [3:0] fn, input logic [63:0] a,
                                    input logic [63:0] b);
        logic [64:0] s;
        if (fn == 4'd0) begin
            s = {b[63], b} + {a[63], a};
            return s[64] ^ s[63];
        end else if (fn == 4'd1) begin
            s = {b[63], b} - {a[63], a};
            return s[64] ^ s[63];
        end
        return 1'b0;
    endfunction

    function automatic logic ref_cnd(input logic [3:0] ic, input logic [3:0] fn);
        logic lt;
        lt = m_sf ^ m_of;
        if (ic != 4'd2 && ic != 4'd7) return 1'b0;
        case (fn)
            4'd0: return 1'b1;
            4'd1: return lt | m_zf;
            4'd2: return lt;
            4'd3: return m_zf;
            4'd4: return !m_zf;
            4'd5: return !lt;
            4'd6: return !lt && !m_zf;
            default: return 1'b0;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_zf <= 1'b1;
            m_sf <= 1'b0;
            m_of <= 1'b0;
        end else if (bus.icode == 4'd6) begin
            logic [63:0] r;
            r = ref_vale(4'd6, bus.ifun, bus.valA, bus.valB, bus.valC);
            m_zf <= (r == 64'd0);
            m_sf <= r[63];
            m_of <= ref_of(bus.ifun, bus.valA, bus.valB);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
    endtask

    task automatic check_cc(input string tag, input logic [2:0] exp);
        logic [2:0] v;
        v = dut.cc;
        check(tag, 64'(v), 64'(exp));
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 time unit later.
    task automatic drive(input logic [3:0] ic, input logic [3:0] fn, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] c);
        @(negedge clk);
        bus.icode = ic;
        bus.ifun  = fn;
        bus.valA  = a;
        bus.valB  = b;
        bus.valC  = c;
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, ".valE"}, bus.valE,
              ref_vale(bus.icode, bus.ifun, bus.valA, bus.valB, bus.valC));
        check({tag, ".cnd"}, 64'(bus.cnd), 64'(ref_cnd(bus.icode, bus.ifun)));
    endtask

    function automatic logic [63:0] pick();
        case ($urandom_range(0, 5))
            0: return 64'd0;
            1: return 64'h7FFF_FFFF_FFFF_FFFF;
            2: return 64'h8000_0000_0000_0000;
            3: return 64'(int'($urandom_range(0, 32)) - 16);
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] ic;
        logic [3:0] fn;

        bus.icode = 4'd0;
        bus.ifun  = 4'd0;
        bus.valA  = '0;
        bus.valB  = '0;
        bus.valC  = '0;

        // Reset state
        drive(4'd7, 4'd3, 64'd0, 64'd0, 64'd0);
        check_cc("reset.cc", 3'b100);
        check("reset.je", 64'(bus.cnd), 64'd1);
        rst_n = 1'b1;
        drive(4'd7, 4'd4, 64'd0, 64'd0, 64'd0);
        check("jne", 64'(bus.cnd), 64'd0);

        // subq 92 from 4
        drive(4'd6, 4'd1, 64'd92, 64'd4, 64'd0);
        check("subq.valE", bus.valE, 64'hFFFF_FFFF_FFFF_FFA8);
        check_model("subq");
        drive(4'd2, 4'd1, 64'h456, 64'd0, 64'd0);
        check_cc("subq.cc", 3'b010);
        check("cmovle.cnd", 64'(bus.cnd), 64'd1);
        check("cmovle.valE", bus.valE, 64'h456);
        drive(4'd2, 4'd6, 64'h666, 64'd0, 64'd0);
        check("cmovg.cnd", 64'(bus.cnd), 64'd0);
        check("cmovg.valE", bus.valE, 64'h666);

        // Signed overflow on add
        drive(4'd6, 4'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0);
        check("addq_ovf.valE", bus.valE, 64'hFFFF_FFFF_FFFF_FFFE);
        drive(4'd2, 4'd2, 64'd5, 64'd0, 64'd0);
        check_cc("addq_ovf.cc", 3'b011);
        check("cmovl.cnd", 64'(bus.cnd), 64'd0);

        // xor to zero, then irmovq leaves CC alone
        drive(4'd6, 4'd3, 64'h1234, 64'h1234, 64'd0);
        check("xorq.valE", bus.valE, 64'd0);
        drive(4'd3, 4'd0, 64'd0, 64'd0, 64'h10);
        check_cc("xorq.cc", 3'b100);
        check("irmovq.valE", bus.valE, 64'h10);
        drive(4'd8, 4'd0, 64'd0, 64'h100, 64'd0);
        check_cc("irmovq.cc", 3'b100);
        check("call.valE", bus.valE, 64'hF8);
        drive(4'd9, 4'd0, 64'd0, 64'h100, 64'd0);
        check("ret.valE", bus.valE, 64'h108);
        drive(4'd5, 4'd0, 64'd0, 64'h20, 64'd8);
        check("mrmovq.valE", bus.valE, 64'h28);

        // Unsupported OPq ifun: result 0, CC still written
        drive(4'd6, 4'd9, 64'd3, 64'd5, 64'd0);
        check("opq_bad.valE", bus.valE, 64'd0);
        drive(4'd6, 4'd0, 64'd1, 64'd1, 64'd0);
        check_cc("opq_bad.cc", 3'b100);

        // Asynchronous reset mid-sequence
        drive(4'd7, 4'd3, 64'd0, 64'd0, 64'd0);
        check_cc("pre_rst.cc", 3'b000);
        check("pre_rst.je", 64'(bus.cnd), 64'd0);
        rst_n = 1'b0;
        #1;
        check_cc("async_rst.cc", 3'b100);
        check("async_rst.je", 64'(bus.cnd), 64'd1);
        #1;
        rst_n = 1'b1;

        // Randomized instructions against the model
        for (int unsigned i = 0; i < 300; i++) begin
            ic = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 2) == 0) ic = 4'd6;
            if ($urandom_range(0, 3) == 0) fn = 4'($urandom_range(0, 15));
            else fn = 4'($urandom_range(0, 7));
            drive(ic, fn, pick(), pick(), pick());
            check_model("rand");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/execute_super.md
Name: execute_super

Overview:
Execute stage of the Y86-64 pipeline. It computes valE through a 64-bit ALU and holds the condition-code register (OF, SF, ZF). It also evaluates the branch/move condition cnd for conditional moves and jumps. The stage sits between decode (valA, valB, valC, icode, ifun) and memory/writeback (valE, cnd).

Parameters:
WIDTH, 64, datapath width of valA/valB/valC/valE.

Ports:
clk  input  1  system clock; CC register updates on rising edge.
rst_n  input  1  asynchronous active-low reset.
icode  input  4  instruction code.
ifun  input  4  function code: ALU op for OPq, condition for cmovXX/jXX.
valA  input  WIDTH  signed operand A.
valB  input  WIDTH  signed operand B.
valC  input  WIDTH  signed constant/displacement.
valE  output  WIDTH  signed ALU result; combinational.
cnd  output  1  condition result; combinational.

Behaviour:
- ALU operands and operation by icode (valE = ALUb op ALUa):
  - 0 halt, 1 nop: valE = 0.
  - 2 rrmovq/cmovXX: valA + 0.
  - 3 irmovq: valC + 0.
  - 4 rmmovq, 5 mrmovq: valB + valC.
  - 6 OPq: valB op valA.
  - 7 jXX: valE = 0.
  - 8 call, A pushq: valB - 8.
  - 9 ret, B popq: valB + 8.
  - Any other icode: valE = 0.
- OPq ops by ifun: 0 add, 1 sub (valB - valA), 2 and, 3 xor. Any other ifun gives valE = 0, and CC is still updated from that result.
- Arithmetic is two's complement and wraps modulo 2^64.
- CC register holds ZF, SF and OF, encoded as cc[2]=ZF, cc[1]=SF, cc[0]=OF.
  - Written only when icode==6, on the rising clk edge.
  - ZF = (valE==0). SF = valE[63].
  - OF for add: (a[63]==b[63]) && (r[63]!=b[63]).
  - OF for sub (b-a): (a[63]!=b[63]) && (r[63]!=b[63]).
  - OF = 0 for and/xor.
- Reset: asynchronous on rst_n low, CC <= {ZF=1, SF=0, OF=0}. valE and cnd are combinational and follow the reset CC value.
- cnd is computed combinationally from the currently registered CC. An OPq therefore affects the conditions of the following instruction, not its own.
- cnd valid for icode 2 and 7; cnd = 0 for all other icodes. Conditions by ifun:
  - 0 always: 1.
  - 1 le: (SF^OF)|ZF.
  - 2 l: SF^OF.
  - 3 e: ZF.
  - 4 ne: !ZF.
  - 5 ge: !(SF^OF).
  - 6 g: !(SF^OF) & !ZF.
  - Other ifun: 0.
- cmovXX: valE = valA regardless of cnd; downstream uses cnd to suppress the write.
- Latency: valE and cnd are zero-cycle combinational. CC has one-cycle latency.

Decomposition:
- Shared package y86_pkg: icode constants (IHALT..IPOPQ), ALU op codes (ALUADD, ALUSUB, ALUAND, ALUXOR), condition codes (C_YES, C_LE, C_L, C_E, C_NE, C_GE, C_G), CC bit indices.
- One sub-module, alu64: inputs a, b, op; outputs result and flags zf, sf, of.
- execute_super contains operand/op selection muxes, the CC register and the condition logic.

Test Plan:
- Reset, then icode=7, ifun=3 (je) -> cnd=1. icode=7, ifun=4 (jne) -> cnd=0.
- icode=6, ifun=1, valA=92, valB=4 -> valE=-88 (0xFFFFFFFFFFFFFFA8). After the clk edge, SF=1, ZF=0, OF=0.
- After the above: icode=2, ifun=1 (cmovle), valA=0x456, valB=0 -> cnd=1, valE=0x456. icode=2, ifun=6 (cmovg), valA=0x666 -> cnd=0, valE=0x666.
- icode=6, ifun=0, valA=valB=0x7FFFFFFFFFFFFFFF -> valE=0xFFFFFFFFFFFFFFFE; after clk OF=1, SF=1. Then cmovl -> cnd=0.
- icode=6, ifun=3, valA=valB=0x1234 -> valE=0; after clk ZF=1. icode 3 with valC=0x10 -> valE=0x10 and CC unchanged.
- icode=8, valB=0x100 -> valE=0xF8. icode=9, valB=0x100 -> valE=0x108. icode=5, valB=0x20, valC=8 -> valE=0x28. Assert rst_n low mid-sequence -> CC returns to ZF=1 without waiting for a clk edge.
